// File: rtl/spi_resp.sv
// 16-bit SPI responder: oversamples SCLK/SS_n/MOSI with clk, shifts on SCLK rise (MSB first),
// presents each complete frame on rx_cmd with a one-clock cmd_rdy strobe.
module spi_resp #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SYNC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SCLK,
    input  logic             SS_n,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_ld,
    output logic [WIDTH-1:0] rx_cmd,
    output logic             cmd_rdy,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StActive, StWaitSs} state_e;

    // SCLK carries one extra stage so the rise is seen between the last two stages.
    logic [SYNC:0]   sclk_q;
    logic [SYNC-1:0] ss_q;
    logic [SYNC-1:0] mosi_q;

    logic sclk_s, sclk_prev, ss_s, mosi_s, sclk_rise;

    state_e           state_q;
    logic [WIDTH-1:0] shft_q;
    logic [WIDTH-1:0] tx_buf_q;
    logic [WIDTH-1:0] rx_cmd_q;
    logic [CntW-1:0]  bit_cnt_q;
    logic             cmd_rdy_q;
    logic             frame_err_q;
    logic             busy_q;

    logic [WIDTH-1:0] shift_nxt;
    logic             last_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '1;
            ss_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC-1:0], SCLK};
            ss_q   <= {ss_q[SYNC-2:0], SS_n};
            mosi_q <= {mosi_q[SYNC-2:0], MOSI};
        end
    end

    // MOSI is taken from the same stage depth as sclk_s, so it is the bit seen at the rise.
    assign sclk_s    = sclk_q[SYNC-1];
    assign sclk_prev = sclk_q[SYNC];
    assign ss_s      = ss_q[SYNC-1];
    assign mosi_s    = mosi_q[SYNC-1];
    assign sclk_rise = sclk_s & ~sclk_prev;

    assign shift_nxt = {shft_q[WIDTH-2:0], mosi_s};
    assign last_bit  = sclk_rise && (bit_cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shft_q      <= '0;
            tx_buf_q    <= '0;
            rx_cmd_q    <= '0;
            bit_cnt_q   <= '0;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
            if (tx_ld) begin
                tx_buf_q <= tx_data;
            end
            case (state_q)
                StIdle: begin
                    if (sclk_rise && !ss_s) begin
                        shft_q    <= shift_nxt;
                        bit_cnt_q <= CntW'(1);
                        busy_q    <= 1'b1;
                        state_q   <= StActive;
                    end else begin
                        shft_q    <= tx_buf_q;
                        bit_cnt_q <= '0;
                    end
                end
                StActive: begin
                    if (sclk_rise) begin
                        shft_q    <= shift_nxt;
                        bit_cnt_q <= bit_cnt_q + CntW'(1);
                    end
                    // A final rise wins over a coincident SS_n release.
                    if (last_bit) begin
                        rx_cmd_q  <= shift_nxt;
                        cmd_rdy_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= StWaitSs;
                    end else if (ss_s) begin
                        frame_err_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                StWaitSs: begin
                    if (ss_s) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign MISO      = shft_q[WIDTH-1];
    assign rx_cmd    = rx_cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_resp.sv
// Bench for spi_resp: acts as a 1:32 SPI initiator and checks frames against a word-level model.
module tb_spi_resp;

    localparam int W    = 16;
    localparam int HALF = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          SCLK, SS_n, MOSI, MISO;
    logic [W-1:0]  tx_data, rx_cmd;
    logic          tx_ld, cmd_rdy, frame_err, busy;

    int errors = 0;
    int checks = 0;

    int           n_rdy = 0;
    int           n_err = 0;
    int           n_both = 0;
    logic [W-1:0] m_tx_buf = '0;
    logic [W-1:0] m_rx = '0;

    spi_resp #(.WIDTH(W), .SYNC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (SCLK),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .tx_data   (tx_data),
        .tx_ld     (tx_ld),
        .rx_cmd    (rx_cmd),
        .cmd_rdy   (cmd_rdy),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_rdy) n_rdy++;
        if (frame_err) n_err++;
        if (cmd_rdy && frame_err) n_both++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [W-1:0] d);
        @(negedge clk);
        tx_data = d;
        tx_ld   = 1'b1;
        @(negedge clk);
        tx_ld    = 1'b0;
        m_tx_buf = d;
        idle(4);
    endtask

    // Initiator: SS_n low, nbits SCLK cycles (MOSI set on fall, MISO sampled just before rise).
    task automatic send_frame(input logic [W-1:0] word, input int nbits, input bit ss_last,
                              input bit abort, input int load_at, input logic [W-1:0] load_val,
                              output logic [W-1:0] rd, output logic busy_mid);
        rd       = '0;
        busy_mid = 1'b0;
        @(negedge clk);
        SS_n = 1'b0;
        idle(HALF);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            SCLK = 1'b0;
            if (i < W) MOSI = word[W-1-i];
            else MOSI = 1'($urandom % 2);
            if (i == load_at) begin
                tx_data = load_val;
                tx_ld   = 1'b1;
                @(negedge clk);
                tx_ld    = 1'b0;
                m_tx_buf = load_val;
                idle(HALF - 2);
            end else begin
                idle(HALF - 1);
            end
            if (i < W) rd[W-1-i] = MISO;
            if (i == 8) busy_mid = busy;
            @(negedge clk);
            SCLK = 1'b1;
            if (ss_last && i == nbits - 1) SS_n = 1'b1;
            idle(HALF - 1);
        end
        if (!abort) begin
            idle(HALF);
            @(negedge clk);
            SS_n = 1'b1;
            idle(HALF);
        end
    endtask

    task automatic test_reset;
        SS_n = 1'b0; SCLK = 1'b1; MOSI = 1'b0; tx_ld = 1'b0; tx_data = '0;
        rst = 1'b1;
        idle(3);
        checks += 5;
        if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", MISO); end
        if (rx_cmd !== '0) begin errors++; $display("FAIL reset_rx: got %h want 0000", rx_cmd); end
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", cmd_rdy); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        m_tx_buf = '0;
        m_rx     = '0;
        idle(4);
    endtask

    task automatic test_first_frame;
        logic [W-1:0] rd;
        logic bm;
        int r0, e0;
        r0 = n_rdy; e0 = n_err;
        send_frame(16'h3C96, W, 1'b0, 1'b0, -1, '0, rd, bm);
        m_rx = 16'h3C96;
        checks += 4;
        if (n_rdy - r0 !== 1) begin errors++; $display("FAIL first_rdy_count: got %0d want 1", n_rdy - r0); end
        if (n_err - e0 !== 0) begin errors++; $display("FAIL first_err_count: got %0d want 0", n_err - e0); end
        if (rx_cmd !== m_rx) begin errors++; $display("FAIL first_rx: got %h want %h", rx_cmd, m_rx); end
        if (rd !== 16'h0000) begin errors++; $display("FAIL first_miso: got %h want 0000", rd); end
    endtask

    task automatic test_basic;
        logic [W-1:0] rd;
        logic bm;
        int r0;
        load_tx(16'hA5C3);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_before: got %b want 0", busy); end
        r0 = n_rdy;
        send_frame(16'h1234, W, 1'b0, 1'b0, -1, '0, rd, bm);
        m_rx = 16'h1234;
        checks += 5;
        if (n_rdy - r0 !== 1) begin errors++; $display("FAIL basic_rdy_count: got %0d want 1", n_rdy - r0); end
        if (rx_cmd !== m_rx) begin errors++; $display("FAIL basic_rx: got %h want %h", rx_cmd, m_rx); end
        if (rd !== 16'hA5C3) begin errors++; $display("FAIL basic_miso: got %h want a5c3", rd); end
        if (bm !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b want 1", bm); end
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] rd, exp_tx;
        logic bm;
        exp_tx = m_tx_buf;
        send_frame(16'hFFFF, W, 1'b0, 1'b0, 5, 16'h8001, rd, bm);
        checks += 2;
        if (rx_cmd !== 16'hFFFF) begin errors++; $display("FAIL b2b_rx1: got %h want ffff", rx_cmd); end
        if (rd !== exp_tx) begin errors++; $display("FAIL b2b_miso1: got %h want %h", rd, exp_tx); end
        send_frame(16'h0001, W, 1'b0, 1'b0, -1, '0, rd, bm);
        m_rx = 16'h0001;
        checks += 2;
        if (rx_cmd !== m_rx) begin errors++; $display("FAIL b2b_rx2: got %h want %h", rx_cmd, m_rx); end
        if (rd !== 16'h8001) begin errors++; $display("FAIL b2b_miso2: got %h want 8001", rd); end
    endtask

    task automatic test_short_frame;
        logic [W-1:0] rd;
        logic bm;
        int r0, e0;
        r0 = n_rdy; e0 = n_err;
        send_frame(16'h7777, 7, 1'b0, 1'b0, -1, '0, rd, bm);
        checks += 3;
        if (n_err - e0 !== 1) begin errors++; $display("FAIL short_err_count: got %0d want 1", n_err - e0); end
        if (n_rdy - r0 !== 0) begin errors++; $display("FAIL short_rdy_count: got %0d want 0", n_rdy - r0); end
        if (rx_cmd !== m_rx) begin errors++; $display("FAIL short_rx_kept: got %h want %h", rx_cmd, m_rx); end
        send_frame(16'h0F0F, W, 1'b0, 1'b0, -1, '0, rd, bm);
        m_rx = 16'h0F0F;
        checks++;
        if (rx_cmd !== m_rx) begin errors++; $display("FAIL short_next_rx: got %h want %h", rx_cmd, m_rx); end
    endtask

    task automatic test_overrun;
        logic [W-1:0] rd;
        logic bm;
        int r0, e0;
        r0 = n_rdy; e0 = n_err;
        send_frame(16'hBEEF, W + 2, 1'b0, 1'b0, -1, '0, rd, bm);
        m_rx = 16'hBEEF;
        checks += 3;
        if (rx_cmd !== m_rx) begin errors++; $display("FAIL overrun_rx: got %h want %h", rx_cmd, m_rx); end
        if (n_rdy - r0 !== 1) begin errors++; $display("FAIL overrun_rdy_count: got %0d want 1", n_rdy - r0); end
        if (n_err - e0 !== 0) begin errors++; $display("FAIL overrun_err_count: got %0d want 0", n_err - e0); end
    endtask

    task automatic test_ss_with_last;
        logic [W-1:0] rd;
        logic bm;
        int r0, e0;
        r0 = n_rdy; e0 = n_err;
        send_frame(16'hC0DE, W, 1'b1, 1'b0, -1, '0, rd, bm);
        m_rx = 16'hC0DE;
        checks += 3;
        if (rx_cmd !== m_rx) begin errors++; $display("FAIL sslast_rx: got %h want %h", rx_cmd, m_rx); end
        if (n_rdy - r0 !== 1) begin errors++; $display("FAIL sslast_rdy_count: got %0d want 1", n_rdy - r0); end
        if (n_err - e0 !== 0) begin errors++; $display("FAIL sslast_err_count: got %0d want 0", n_err - e0); end
    endtask

    task automatic test_reset_mid_frame;
        logic [W-1:0] rd;
        logic bm;
        int r0, e0;
        r0 = n_rdy; e0 = n_err;
        send_frame(16'h1357, 9, 1'b0, 1'b1, -1, '0, rd, bm);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        checks += 4;
        if (rx_cmd !== '0) begin errors++; $display("FAIL rstmid_rx: got %h want 0000", rx_cmd); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (MISO !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b want 0", MISO); end
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_rdy: got %b want 0", cmd_rdy); end
        SS_n = 1'b1;
        idle(2);
        rst = 1'b0;
        m_tx_buf = '0;
        m_rx     = '0;
        idle(8);
        checks += 2;
        if (n_rdy - r0 !== 0) begin errors++; $display("FAIL rstmid_rdy_count: got %0d want 0", n_rdy - r0); end
        if (n_err - e0 !== 0) begin errors++; $display("FAIL rstmid_err_count: got %0d want 0", n_err - e0); end
        send_frame(16'h5A5A, W, 1'b0, 1'b0, -1, '0, rd, bm);
        m_rx = 16'h5A5A;
        checks += 2;
        if (rx_cmd !== m_rx) begin errors++; $display("FAIL rstmid_next_rx: got %h want %h", rx_cmd, m_rx); end
        if (rd !== 16'h0000) begin errors++; $display("FAIL rstmid_next_miso: got %h want 0000", rd); end
    endtask

    task automatic test_random;
        logic [W-1:0] rd, word, exp_tx;
        logic bm;
        int nbits, r0, e0;
        bit ss_last;
        for (int f = 0; f < 24; f++) begin
            if ($urandom % 2 == 1) load_tx(W'($urandom));
            exp_tx  = m_tx_buf;
            word    = W'($urandom);
            nbits   = ($urandom % 10 < 6) ? W : int'($urandom_range(1, W + 2));
            ss_last = (nbits == W) && ($urandom % 3 == 0);
            r0 = n_rdy; e0 = n_err;
            send_frame(word, nbits, ss_last, 1'b0, -1, '0, rd, bm);
            checks += 3;
            if (nbits >= W) begin
                m_rx = word;
                checks++;
                if (rd !== exp_tx) begin errors++; $display("FAIL rand_miso[%0d]: got %h want %h", f, rd, exp_tx); end
            end
            if (rx_cmd !== m_rx) begin errors++; $display("FAIL rand_rx[%0d]: got %h want %h", f, rx_cmd, m_rx); end
            if (n_rdy - r0 !== (nbits >= W ? 1 : 0)) begin
                errors++; $display("FAIL rand_rdy_count[%0d]: got %0d bits=%0d", f, n_rdy - r0, nbits);
            end
            if (n_err - e0 !== (nbits >= W ? 0 : 1)) begin
                errors++; $display("FAIL rand_err_count[%0d]: got %0d bits=%0d", f, n_err - e0, nbits);
            end
        end
        checks++;
        if (n_both !== 0) begin errors++; $display("FAIL rdy_err_overlap: got %0d want 0", n_both); end
    endtask

    initial begin
        test_reset;
        test_first_frame;
        test_basic;
        test_back_to_back;
        test_short_frame;
        test_overrun;
        test_ss_with_last;
        test_reset_mid_frame;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
